// File: rtl/uart_fifo_tx_if.sv
// Read-side connection to a byte FIFO whose data_out is registered one cycle after the read strobe.
// master = the consumer that owns the read strobe, slave = the FIFO.
interface uart_fifo_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 fifo_read;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_read
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_read
    );
endinterface

// File: rtl/uart_fifo_tx.sv
// Pops bytes from the TX FIFO and serialises them as 8N1 frames; tx falls 2 edges after the read strobe.
// Backpressure: a byte is popped only when the FIFO is non-empty and the line is idle or finishing a stop bit.
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic           CLOCK_50,
    input  logic           RST,
    uart_fifo_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state          <= IDLE;
            tx             <= 1'b1;
            fifo.fifo_read <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            bit_idx        <= '0;
            cyc_cnt        <= '0;
            shift          <= '0;
        end else begin
            fifo.fifo_read <= 1'b0;
            frame_done     <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo.fifo_empty) begin
                        fifo.fifo_read <= 1'b1;
                        busy           <= 1'b1;
                        state          <= REQ;
                    end
                end
                // FIFO pops on this edge; its data_out is valid during LOAD.
                REQ: state <= LOAD;
                LOAD: begin
                    shift   <= fifo.fifo_data;
                    tx      <= 1'b0;
                    cyc_cnt <= '0;
                    state   <= START;
                end
                START: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        if (!fifo.fifo_empty) begin
                            fifo.fifo_read <= 1'b1;
                            state          <= REQ;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                        // Registered, so raising it one count early lands it on the final stop cycle.
                        if (cyc_cnt == CNT_PRE) frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
